// File: rtl/cpu_press_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_press_gen
//  Purpose  : Computer-player press source for Tug-of-War. A free-running
//             10-bit LFSR is sampled on a prescaled tick and compared against
//             the switch threshold; a win emits a one-cycle press followed by
//             a cooldown measured in ticks.
//  Options  : define PRESS_CNT_EN to add the saturating press_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_press_gen #(
    parameter int               WIDTH    = 10,
    parameter int               TICK_DIV = 16,
    parameter int               COOLDOWN = 4,
    parameter logic [WIDTH-1:0] SEED     = 10'd1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] threshold,
    output logic             press,
    output logic [WIDTH-1:0] rand_val,
    output logic             busy
`ifdef PRESS_CNT_EN
    ,
    output logic [7:0]       press_cnt
`endif
);

    localparam int c_PW = $clog2(TICK_DIV);
    localparam int c_CW = $clog2(COOLDOWN + 1);

    localparam logic [1:0] c_ARMED = 2'd0;
    localparam logic [1:0] c_PRESS = 2'd1;
    localparam logic [1:0] c_COOL  = 2'd2;

    logic [c_PW-1:0]  r_presc;
    logic [WIDTH-1:0] r_lfsr;
    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cool;
    logic             r_press;

    logic             w_tick;
    logic             w_fire;
    logic             w_fb;

    assign w_tick = enable && (r_presc == c_PW'(TICK_DIV - 1));
    // Compare uses the LFSR value present before this tick advances it.
    assign w_fire = w_tick && (r_state == c_ARMED) && (threshold > r_lfsr);
    assign w_fb   = r_lfsr[WIDTH-1] ^ r_lfsr[6];

    assign press    = r_press;
    assign rand_val = r_lfsr;
    assign busy     = (r_state == c_COOL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (!enable || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    // The all-zero lockup state is self-healing rather than relying on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= SEED;
        end else if (r_lfsr == '0) begin
            r_lfsr <= SEED;
        end else if (w_tick) begin
            r_lfsr <= {r_lfsr[WIDTH-2:0], w_fb};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ARMED;
            r_cool  <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            case (r_state)
                c_ARMED: begin
                    if (w_fire) begin
                        r_press <= 1'b1;
                        r_state <= c_PRESS;
                        r_cool  <= c_CW'(COOLDOWN);
                    end
                end
                c_PRESS: begin
                    // A tick landing on the entry cycle already counts down.
                    if (w_tick && (r_cool == c_CW'(1))) begin
                        r_state <= c_ARMED;
                    end else begin
                        r_state <= c_COOL;
                        if (w_tick) begin
                            r_cool <= r_cool - c_CW'(1);
                        end
                    end
                end
                c_COOL: begin
                    if (w_tick) begin
                        if (r_cool == c_CW'(1)) begin
                            r_state <= c_ARMED;
                        end else begin
                            r_cool <= r_cool - c_CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_ARMED;
                end
            endcase
        end
    end

`ifdef PRESS_CNT_EN
    logic [7:0] r_pcnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt <= 8'd0;
        end else if (w_fire && (r_pcnt != 8'hFF)) begin
            r_pcnt <= r_pcnt + 8'd1;
        end
    end

    assign press_cnt = r_pcnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_press_gen.sv
`default_nettype none
// Scoreboard bench for cpu_press_gen (TICK_DIV=4, COOLDOWN=2): stimulus queues
// expected presses and state snapshots; a negedge monitor pops and compares.
module tb_cpu_press_gen;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       enable    = 1'b0;
    logic [9:0] threshold = 10'd0;
    logic       press;
    logic [9:0] rand_val;
    logic       busy;
`ifdef PRESS_CNT_EN
    logic [7:0] press_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;
    bit chk_press = 1'b1;

    typedef struct {
        int         cyc;
        logic [9:0] rv;
    } pexp_t;

    typedef struct {
        int         cyc;
        logic [9:0] rv;
        logic       bz;
    } sexp_t;

    pexp_t pq[$];
    sexp_t sq[$];
    pexp_t pe;
    sexp_t se;

    int lfsr_tbl[8] = '{2, 4, 8, 16, 32, 64, 129, 258};

    cpu_press_gen #(
        .WIDTH    (10),
        .TICK_DIV (4),
        .COOLDOWN (2),
        .SEED     (10'd1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .threshold (threshold),
        .press     (press),
        .rand_val  (rand_val),
        .busy      (busy)
`ifdef PRESS_CNT_EN
        ,
        .press_cnt (press_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: consumes expectations as the DUT presents presses and snapshot cycles.
    always @(negedge clk) begin
        if (reset_n) begin
            while (pq.size() > 0 && pq[0].cyc < cyc) begin
                pe = pq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_press: required press at cycle %0d rand %0d did not occur", pe.cyc, pe.rv);
            end
            if (press && chk_press) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_press: press at cycle %0d rand %0d, required none", cyc, rand_val);
                end else begin
                    pe = pq.pop_front();
                    if (pe.cyc != cyc || pe.rv != rand_val) begin
                        errors++;
                        $display("FAIL press: got cycle %0d rand %0d, required cycle %0d rand %0d",
                                 cyc, rand_val, pe.cyc, pe.rv);
                    end
                end
            end
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                se = sq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_snapshot: cycle %0d not sampled", se.cyc);
            end
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                se = sq.pop_front();
                checks++;
                if (se.rv != rand_val || se.bz != busy) begin
                    errors++;
                    $display("FAIL snapshot@%0d: got rand %0d busy %0b, required rand %0d busy %0b",
                             cyc, rand_val, busy, se.rv, se.bz);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic exp_press(input int c, input int rv);
        pexp_t p;
        p.cyc = c;
        p.rv  = rv[9:0];
        pq.push_back(p);
    endtask

    task automatic exp_snap(input int c, input int rv, input logic bz);
        sexp_t s;
        s.cyc = c;
        s.rv  = rv[9:0];
        s.bz  = bz;
        sq.push_back(s);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Asynchronous reset between clock edges; outputs must clear with no edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        chk("reset_rand", int'(rand_val), 1);
        chk("reset_press", int'(press), 0);
        chk("reset_busy", int'(busy), 0);
`ifdef PRESS_CNT_EN
        chk("reset_press_cnt", int'(press_cnt), 0);
`endif
    endtask

    task automatic release_rst(input int thr);
        @(negedge clk);
        threshold = thr[9:0];
        enable    = 1'b1;
        reset_n   = 1'b1;
        base      = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);

        // LFSR sequence with threshold 0, then rand_val == threshold boundary.
        release_rst(0);
        exp_snap(base + 3, 1, 1'b0);
        for (int k = 0; k < 8; k++) exp_snap(base + 4 * (k + 1), lfsr_tbl[k], 1'b0);
        wait_cyc(base + 26);
        threshold = 10'd64;
        wait_cyc(base + 30);
        threshold = 10'd0;
        wait_cyc(base + 34);

        // First press, cooldown spacing, enable drop, then mid-cooldown reset.
        do_reset();
        release_rst(1023);
        exp_press(base + 4, 2);
        exp_press(base + 16, 16);
        exp_press(base + 28, 129);
        exp_press(base + 52, 9);
        exp_snap(base + 4, 2, 1'b0);
        exp_snap(base + 5, 2, 1'b1);
        exp_snap(base + 11, 4, 1'b1);
        exp_snap(base + 12, 8, 1'b0);
        exp_snap(base + 32, 129, 1'b1);
        exp_snap(base + 36, 129, 1'b1);
        exp_snap(base + 40, 129, 1'b1);
        exp_snap(base + 44, 258, 1'b1);
        exp_snap(base + 48, 516, 1'b0);
        exp_snap(base + 53, 9, 1'b1);
        wait_cyc(base + 30);
        enable = 1'b0;
        wait_cyc(base + 40);
        enable = 1'b1;
        wait_cyc(base + 54);
        do_reset();

        // threshold one above rand_val fires.
        release_rst(0);
        exp_press(base + 28, 129);
        exp_snap(base + 29, 129, 1'b1);
        wait_cyc(base + 26);
        threshold = 10'd65;
        wait_cyc(base + 29);
        threshold = 10'd0;
        wait_cyc(base + 34);

`ifdef PRESS_CNT_EN
        do_reset();
        chk_press = 1'b0;
        release_rst(1023);
        wait_cyc(base + 300 * 12 + 400);
        chk("press_cnt_saturate", int'(press_cnt), 255);
        do_reset();
        chk_press = 1'b1;
        release_rst(0);
        wait_cyc(base + 4);
`endif

        wait_cyc(cyc + 2);
        chk("queues_drained", pq.size() + sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
